data_source_gen: RTL and testbench
==================================

// Module: data_source_gen
// PURPOSE
//  Parametrised test-pattern source for the SSD controller datapath; feeds write-path/FIFO benches and link bring-up.
//  Emits fixed-length bursts over a valid/ready stream. Beat 0 of each burst is a header carrying a burst sequence number.
//  The remaining beats carry a mode-selected payload: incrementing, PRBS, walking-one or constant.
//  Supports back-pressure and clean stop at burst boundaries.
// PARAMETERS
//  DATA_W     8      data width in bits, >=4
//  BURST_LEN  256    beats per burst including header, >=2
//  SEED       8'h01  LFSR reset value; 0 is forced to 1
//  TAPS       8'hB8  Galois LFSR tap mask, DATA_W bits
//  CONST_VAL  8'hA5  payload for CONST mode
// PORTS
//  clk        in   1       clock
//  nRST       in   1       async reset, active low
//  en         in   1       run request; sampled in IDLE and at each burst end
//  mode       in   2       0 INCR, 1 PRBS, 2 WALK, 3 CONST; latched at burst start
//  data_ready in   1       sink ready
//  data_out   out  DATA_W  beat data
//  data_valid out  1       beat valid
//  data_last  out  1       high on final beat (index BURST_LEN-1)
//  seq_num    out  DATA_W  sequence number of the current/next burst
// BEHAVIOUR
//  Reset: nRST asynchronous, active-low; clock clk. All outputs 0; state IDLE; lfsr=SEED (or 1 if SEED is 0); walk=1; beat=0.
//  Outputs are registered; accept = data_valid & data_ready.
//  FSM:
//   IDLE -> HDR on the first edge with en=1. data_valid=1 after that edge: 1-cycle latency. mode latched at this edge.
//   HDR: data_out=seq_num, beat 0. On accept -> PAY, beat=1.
//   PAY: payload beats 1..BURST_LEN-1. data_last=1 on beat BURST_LEN-1. On accept of last: seq_num++ (wraps 2^DATA_W-1->0), beat=0.
//   At that edge, en=1 -> HDR with the new mode relatched. en=0 -> IDLE with data_valid=0.
//  en deassert mid-burst: burst completes fully; no truncation.
//  mode change mid-burst: ignored until next burst start.
//  Stall: while data_valid & !data_ready, data_out, data_last, beat, lfsr and walk all hold.
//  Payload on beat i (advances only on accept):
//   INCR  : i mod 2^DATA_W
//   PRBS  : current lfsr. On accept: lfsr = (lfsr>>1) ^ (lfsr[0] ? TAPS : 0).
//           lfsr runs continuously across bursts and is never reloaded except by reset.
//   WALK  : walk reg. Set to 1 at each HDR accept; rotate left by 1 on each payload accept.
//   CONST : CONST_VAL
//  Header beat never advances lfsr or walk.
//  beat counter width = clog2(BURST_LEN); wraps only via last-beat logic.
//  Reset mid-burst: immediate return to reset values. The partial burst is discarded; seq_num restarts at 0.
//  data_ready is ignored when data_valid=0. data_valid never drops without accept, except on reset.
// TESTING
//  T1 reset/latency: nRST low then high, en=1 at edge k -> data_valid=1 after k, data_out=0x00 (seq 0), data_last=0.
//  T2 INCR, ready=1, BURST_LEN=4 -> 00,01,02,03 then 01,01,02,03. data_last on beats 3 and 7. seq_num=2 after two bursts.
//  T3 PRBS, SEED=1, TAPS=B8, BURST_LEN=4 -> 00,01,B8,5C; next burst 01,2E,17,B3.
//  T4 back-pressure: WALK, ready toggles 1/0 per cycle -> payload 01,02,04 each held 2 cycles; no beat lost or duplicated.
//  T5 en dropped on beat 1 of 4 -> beats 2,3 still emitted, data_valid=0 after last accept; mode changed mid-burst has no effect.
//  T6 nRST pulsed mid-PAY -> outputs 0 next sample; restart emits seq 0 and PRBS resumes from SEED.

Source files
------------

// File: rtl/data_source_gen.sv
// -----------------------------------------------------------------------------
// data_source_gen
//   Test-pattern source for the SSD controller datapath. Emits fixed-length
//   bursts on a valid/ready stream: beat 0 is a header carrying the burst
//   sequence number, beats 1..BURST_LEN-1 carry a payload selected by mode
//   (incrementing, PRBS, walking-one or constant). Stops only at burst ends.
//
// Ports
//   clk         clock
//   nRST        asynchronous reset, active low
//   en          run request, sampled in IDLE and at each burst end
//   mode        0 INCR, 1 PRBS, 2 WALK, 3 CONST; latched at burst start
//   data_ready  sink ready
//   data_out    beat data (registered)
//   data_valid  beat valid (registered)
//   data_last   final beat of burst (registered)
//   seq_num     sequence number of the current/next burst
// -----------------------------------------------------------------------------
module data_source_gen #(
  parameter int                DATA_W    = 8,
  parameter int                BURST_LEN = 256,
  parameter logic [DATA_W-1:0] SEED      = 8'h01,
  parameter logic [DATA_W-1:0] TAPS      = 8'hB8,
  parameter logic [DATA_W-1:0] CONST_VAL = 8'hA5
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              data_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              data_last,
  output logic [DATA_W-1:0] seq_num
);

  localparam int                BEAT_W    = $clog2(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  // An all-zero Galois LFSR is stuck forever, so a zero seed becomes 1.
  localparam logic [DATA_W-1:0] LFSR_INIT = (SEED == '0) ? DATA_W'(1) : SEED;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_t;
  typedef enum logic [1:0] {M_INCR, M_PRBS, M_WALK, M_CONST} mode_t;

  state_t            state_q, state_n;
  mode_t             mode_q, mode_n;
  logic [BEAT_W-1:0] beat_q, beat_n;
  logic [DATA_W-1:0] seq_q, seq_n;
  logic [DATA_W-1:0] lfsr_q, lfsr_n;
  logic [DATA_W-1:0] walk_q, walk_n;
  logic [DATA_W-1:0] data_out_n;
  logic              valid_n, last_n;
  logic              accept;

  assign accept  = data_valid & data_ready;
  assign seq_num = seq_q;

  function automatic logic [DATA_W-1:0] payload(input mode_t             m,
                                                input logic [BEAT_W-1:0] b,
                                                input logic [DATA_W-1:0] lfsr,
                                                input logic [DATA_W-1:0] walk);
    case (m)
      M_INCR:  payload = DATA_W'(b);
      M_PRBS:  payload = lfsr;
      M_WALK:  payload = walk;
      default: payload = CONST_VAL;
    endcase
  endfunction

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_n = state_q;
    mode_n  = mode_q;
    beat_n  = beat_q;
    seq_n   = seq_q;
    lfsr_n  = lfsr_q;
    walk_n  = walk_q;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_n = S_HDR;
          mode_n  = mode_t'(mode);
          beat_n  = '0;
        end
      end
      S_HDR: begin
        if (accept) begin
          state_n = S_PAY;
          beat_n  = BEAT_W'(1);
          walk_n  = DATA_W'(1);
        end
      end
      S_PAY: begin
        if (accept) begin
          // Header beats never reach here, so lfsr/walk advance on payload only.
          if (mode_q == M_PRBS)
            lfsr_n = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
          if (mode_q == M_WALK)
            walk_n = {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
          if (beat_q == LAST_BEAT) begin
            beat_n = '0;
            seq_n  = seq_q + DATA_W'(1);
            if (en) begin
              state_n = S_HDR;
              mode_n  = mode_t'(mode);
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            beat_n = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next-state values.
    // During a stall every next value equals the current one, so they hold.
    data_out_n = '0;
    valid_n    = 1'b0;
    last_n     = 1'b0;
    case (state_n)
      S_HDR: begin
        valid_n    = 1'b1;
        data_out_n = seq_n;
      end
      S_PAY: begin
        valid_n    = 1'b1;
        last_n     = (beat_n == LAST_BEAT);
        data_out_n = payload(mode_n, beat_n, lfsr_n, walk_n);
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      mode_q     <= M_INCR;
      beat_q     <= '0;
      seq_q      <= '0;
      lfsr_q     <= LFSR_INIT;
      walk_q     <= DATA_W'(1);
      data_out   <= '0;
      data_valid <= 1'b0;
      data_last  <= 1'b0;
    end else begin
      state_q    <= state_n;
      mode_q     <= mode_n;
      beat_q     <= beat_n;
      seq_q      <= seq_n;
      lfsr_q     <= lfsr_n;
      walk_q     <= walk_n;
      data_out   <= data_out_n;
      data_valid <= valid_n;
      data_last  <= last_n;
    end
  end

endmodule

// File: tb/tb_data_source_gen.sv
// -----------------------------------------------------------------------------
// tb_data_source_gen
//   Self-checking bench for data_source_gen with DATA_W=8, BURST_LEN=4.
//   Expected beats are queued when a run is requested and compared as the
//   DUT hands over each accepted beat. Inputs change 1 time unit after the
//   rising edge; outputs are sampled on the falling edge or just after rise.
// -----------------------------------------------------------------------------
module tb_data_source_gen;

  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       nRST = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       data_ready = 1'b0;
  logic [7:0] data_out, seq_num;
  logic       data_valid, data_last;

  always #5 clk = ~clk;

  data_source_gen #(
    .DATA_W   (8),
    .BURST_LEN(BL),
    .SEED     (8'h01),
    .TAPS     (8'hB8),
    .CONST_VAL(8'hA5)
  ) dut (
    .clk       (clk),
    .nRST      (nRST),
    .en        (en),
    .mode      (mode),
    .data_ready(data_ready),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_last (data_last),
    .seq_num   (seq_num)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  int         total = 0;
  int         bad = 0;
  int         acc_cnt = 0;
  beat_t      sb[$];
  beat_t      exp_b;
  logic [7:0] m_seq = 8'h00;
  logic [7:0] m_lfsr = 8'h01;

  // Scoreboard consumer: every accepted beat must match the head of the queue.
  always @(negedge clk) begin
    if (nRST && data_valid && data_ready) begin
      acc_cnt++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL stream_extra: got data=%h last=%b, no beat expected", data_out, data_last);
      end else begin
        exp_b = sb.pop_front();
        if (data_out !== exp_b.data || data_last !== exp_b.last) begin
          bad++;
          $display("FAIL stream_beat: got data=%h last=%b, want data=%h last=%b",
                   data_out, data_last, exp_b.data, exp_b.last);
        end
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic l);
    sb.push_back('{data: d, last: l});
  endtask

  // Reference model of one burst.
  task automatic push_burst(input logic [1:0] m);
    logic [7:0] w;
    logic [7:0] d;
    w = 8'h01;
    push(m_seq, 1'b0);
    for (int i = 1; i < BL; i++) begin
      case (m)
        2'd0: d = 8'(i);
        2'd1: begin
          d = m_lfsr;
          m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
        end
        2'd2: begin
          d = w;
          w = {w[6:0], w[7]};
        end
        default: d = 8'hA5;
      endcase
      push(d, i == BL - 1);
    end
    m_seq = m_seq + 8'h01;
  endtask

  // Runs n bursts from IDLE; en drops on beat 1 of the last burst, where mode
  // is also switched to m2. Optionally toggles data_ready every cycle.
  task automatic run_bursts(input int n, input logic [1:0] m, input bit toggle,
                            input logic [7:0] start, input logic [1:0] m2);
    int         cyc;
    int         budget;
    int         acc0;
    bit         chk_hold;
    bit         last_acc;
    logic [7:0] held;
    logic [7:0] exp_seq;
    budget   = n * BL * 3 + 20;
    acc0     = acc_cnt;
    chk_hold = 1'b0;
    mode = m;
    data_ready = 1'b1;
    en = 1'b1;
    @(posedge clk); #1;
    total++;
    if (data_valid !== 1'b1 || data_out !== start || data_last !== 1'b0) begin
      bad++;
      $display("FAIL start_latency: got valid=%b data=%h last=%b, want valid=1 data=%h last=0",
               data_valid, data_out, data_last, start);
    end
    cyc = 0;
    while ((en || sb.size() != 0 || data_valid) && cyc < budget) begin
      if (en && (acc_cnt - acc0) >= (n - 1) * BL + 1) begin
        en = 1'b0;
        mode = m2;
      end
      if (toggle) data_ready = ~data_ready;
      @(negedge clk);
      if (chk_hold) begin
        total++;
        if (data_out !== held) begin
          bad++;
          $display("FAIL stall_hold: got data=%h, want %h", data_out, held);
        end
      end
      chk_hold = data_valid && !data_ready;
      held     = data_out;
      last_acc = data_valid && data_ready && data_last;
      @(posedge clk); #1;
      cyc++;
      if (last_acc) begin
        total++;
        if (data_valid !== en) begin
          bad++;
          $display("FAIL burst_end_valid: got valid=%b, want %b", data_valid, en);
        end
      end
    end
    total++;
    if (cyc >= budget) begin
      bad++;
      $display("FAIL run_timeout: got %0d cycles, limit %0d, %0d beats pending", cyc, budget, sb.size());
    end
    exp_seq = start + 8'(n);
    total++;
    if (seq_num !== exp_seq || data_valid !== 1'b0) begin
      bad++;
      $display("FAIL run_end: got seq=%h valid=%b, want seq=%h valid=0", seq_num, data_valid, exp_seq);
    end
  endtask

  task automatic check_zero(input string tag);
    total++;
    if (data_out !== 8'h00 || data_valid !== 1'b0 || data_last !== 1'b0 || seq_num !== 8'h00) begin
      bad++;
      $display("FAIL %s: got data=%h valid=%b last=%b seq=%h, want all 0",
               tag, data_out, data_valid, data_last, seq_num);
    end
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    #1;
    check_zero("reset_outputs");
    repeat (2) @(posedge clk);
    @(negedge clk);
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_zero("idle_no_en");
    end
  endtask

  task automatic test_incr;
    logic [7:0] s;
    s = m_seq;
    push_burst(2'd0);
    push_burst(2'd0);
    run_bursts(2, 2'd0, 1'b0, s, 2'd0);
  endtask

  // Known-answer sequence for SEED=01, TAPS=B8.
  task automatic test_prbs;
    logic [7:0] s;
    s = m_seq;
    push(s, 1'b0);
    push(8'h01, 1'b0);
    push(8'hB8, 1'b0);
    push(8'h5C, 1'b1);
    push(s + 8'h01, 1'b0);
    push(8'h2E, 1'b0);
    push(8'h17, 1'b0);
    push(8'hB3, 1'b1);
    m_seq  = s + 8'h02;
    m_lfsr = 8'hE1;
    run_bursts(2, 2'd1, 1'b0, s, 2'd1);
  endtask

  task automatic test_back_to_back;
    logic [7:0] s;
    s = m_seq;
    push_burst(2'd2);
    push_burst(2'd2);
    run_bursts(2, 2'd2, 1'b1, s, 2'd2);
  endtask

  // en dropped on beat 1 and mode switched mid-burst: CONST burst completes.
  task automatic test_en_drop;
    logic [7:0] s;
    s = m_seq;
    push_burst(2'd3);
    run_bursts(1, 2'd3, 1'b0, s, 2'd0);
  endtask

  task automatic test_reset_mid;
    logic [7:0] s;
    s = m_seq;
    push_burst(2'd1);
    mode = 2'd1;
    data_ready = 1'b1;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    nRST = 1'b0;
    #1;
    check_zero("reset_mid_pay");
    sb.delete();
    m_seq  = 8'h00;
    m_lfsr = 8'h01;
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk); #1;
    check_zero("after_reset_idle");
    s = m_seq;
    push_burst(2'd1);
    run_bursts(1, 2'd1, 1'b0, s, 2'd1);
  endtask

  task automatic test_seq_wrap;
    logic [7:0] s;
    int         n;
    s = m_seq;
    n = 256 - int'(s) + 1;
    for (int i = 0; i < n; i++) push_burst(2'd0);
    run_bursts(n, 2'd0, 1'b0, s, 2'd0);
  endtask

  initial begin
    test_reset;
    test_incr;
    test_prbs;
    test_back_to_back;
    test_en_drop;
    test_reset_mid;
    test_seq_wrap;
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
